ram32_resp: RTL



---
 rtl/ram32_pkg.sv | 13 +
 rtl/ram32_clear_seq.sv | 63 ++++++
 rtl/ram32_resp.sv | 75 +++++++
 3 files changed

// File: rtl/ram32_pkg.sv
// Shared types and constants for the RAM32 responder and its clear sequencer.
package ram32_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram32_state_e;

    localparam int          RAM32_WIDTH   = 32;
    localparam int          RAM32_LANES   = 4;
    localparam logic [31:0] RAM32_CLR_VAL = 32'h0000_0000;

endpackage : ram32_pkg

// File: rtl/ram32_clear_seq.sv
// Clear sequencer: walks every word address once after reset or an i_clr request, then reports ready.
// One word per cycle, DEPTH cycles total; i_clr is ignored while a clear is already running.
module ram32_clear_seq
    import ram32_pkg::*;
#(
    parameter int  DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    ram32_state_e  state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        o_clr_we = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                o_clr_we = 1'b1;
                // Leave on the last word so the counter never wraps into a second pass.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_clr_addr = cnt_q;
    assign o_ready    = (state_q == ST_READY);

endmodule : ram32_clear_seq

// File: rtl/ram32_resp.sv
// RAM32 responder: DEPTH x 32 flop array, byte-lane writes, registered read (latency 1).
// No backpressure once ready; all user accesses are dropped and dout reads 0 while clearing.
module ram32_resp
    import ram32_pkg::*;
#(
    parameter int          DEPTH   = 32,
    parameter logic [31:0] CLR_VAL = RAM32_CLR_VAL,
    localparam int         AW      = $clog2(DEPTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [AW-1:0]          i_ram_addr,
    input  logic [RAM32_WIDTH-1:0] i_ram_din,
    input  logic [RAM32_LANES-1:0] i_ram_we,
    input  logic                   i_ram_en,
    output logic [RAM32_WIDTH-1:0] o_ram_dout,
    input  logic                   i_clr,
    output logic                   o_ready
);

    logic [RAM32_WIDTH-1:0] mem_q [DEPTH];
    logic [RAM32_WIDTH-1:0] dout_q, dout_d;
    logic                   clr_we;
    logic [AW-1:0]          clr_addr;
    logic                   ready;
    logic                   user_wr;
    logic                   user_rd;

    ram32_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (i_clr),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr),
        .o_ready    (ready)
    );

    assign user_wr = ready && i_ram_en && (i_ram_we != '0);
    assign user_rd = ready && i_ram_en && (i_ram_we == '0);

    // The array is deliberately not reset; the sequencer initialises it.
    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem_q[clr_addr] <= CLR_VAL;
        end else if (user_wr) begin
            for (int n = 0; n < RAM32_LANES; n++) begin
                if (i_ram_we[n]) begin
                    mem_q[i_ram_addr][8*n +: 8] <= i_ram_din[8*n +: 8];
                end
            end
        end
    end

    always_comb begin
        dout_d = dout_q;
        if (!ready) begin
            dout_d = '0;
        end else if (user_rd) begin
            dout_d = mem_q[i_ram_addr];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    // Gate the output so the first clear cycle does not expose a stale read.
    assign o_ram_dout = ready ? dout_q : '0;
    assign o_ready    = ready;

endmodule : ram32_resp
